mult_arbiter: RTL and testbench



---
 rtl/mult_pkg.sv | 13 +
 rtl/mult_arbiter_rr_pick.sv | 28 ++
 rtl/mult_arbiter.sv | 91 +++++++++
 tb/tb_mult_arbiter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and default sizing for the shared-multiplier arbiter.
package mult_pkg;

   localparam int MULT_W    = 4;
   localparam int MULT_NREQ = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/mult_arbiter_rr_pick.sv
// Round-robin picker: first set request at or above ptr, wrapping modulo NREQ.
// Purely combinational so other arbiters can reuse it.
module rr_pick #(
   parameter int NREQ = 4,
   localparam int IDW = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  idx,
   output logic            any
);

   // Scan from the farthest slot back to ptr so the nearest hit is written last.
   always_comb begin
      idx = '0;
      any = 1'b0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req[(int'(ptr) + k) % NREQ]) begin
            idx = IDW'((int'(ptr) + k) % NREQ);
            any = 1'b1;
         end
      end
   end

   assign gnt = any ? (NREQ'(1) << idx) : '0;

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin sequencer sharing one registered multiply stage among NREQ
// requesters. One operation in flight: IDLE (grant) -> MUL -> RESP.
module mult_arbiter
   import mult_pkg::*;
#(
   parameter int NREQ = MULT_NREQ,
   parameter int W    = MULT_W,
   localparam int IDW = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ*W-1:0] req_a,
   input  logic [NREQ*W-1:0] req_b,
   output logic [NREQ-1:0]   req_ready,
   output logic              rsp_valid,
   output logic [IDW-1:0]    rsp_id,
   output logic [2*W-1:0]    rsp_prod,
   input  logic              rsp_ready
);

   state_t          state, state_nx;
   logic [IDW-1:0]  rr_ptr;
   logic [W-1:0]    op_a, op_b;
   logic [IDW-1:0]  op_id;
   logic [NREQ-1:0] pick_gnt;
   logic [IDW-1:0]  pick_idx;
   logic            pick_any;
   logic            accept;

   rr_pick #(.NREQ(NREQ)) u_pick (
      .req (req_valid),
      .ptr (rr_ptr),
      .gnt (pick_gnt),
      .idx (pick_idx),
      .any (pick_any)
   );

   // Grant only while idle; held low during reset so no requester sees a
   // handshake the block is not going to honour.
   assign req_ready = (rst_n && state == IDLE) ? pick_gnt : '0;
   assign accept    = (state == IDLE) && pick_any;

   // Next-state: one cycle to multiply, then hold RESP until the consumer takes it.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (pick_any) state_nx = MUL;
         MUL:     state_nx = RESP;
         RESP:    if (rsp_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Capture the winner's operands and advance the pointer past the winner.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_a   <= '0;
         op_b   <= '0;
         op_id  <= '0;
         rr_ptr <= '0;
      end else if (accept) begin
         op_a   <= req_a[pick_idx*W +: W];
         op_b   <= req_b[pick_idx*W +: W];
         op_id  <= pick_idx;
         rr_ptr <= (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
      end
   end

   // Multiply register and response handshake; outputs stay put through RESP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_prod  <= '0;
      end else if (state == MUL) begin
         rsp_prod  <= {{W{1'b0}}, op_a} * {{W{1'b0}}, op_b};
         rsp_id    <= op_id;
         rsp_valid <= 1'b1;
      end else if (state == RESP && rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: directed scenarios plus randomized traffic, all
// checked cycle by cycle against a transaction-level reference model.
module tb_mult_arbiter;

   localparam int NREQ = 4;
   localparam int W    = 4;
   localparam int IDW  = $clog2(NREQ);

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NREQ-1:0]   req_valid = '0;
   logic [NREQ*W-1:0] req_a = '0, req_b = '0;
   logic [NREQ-1:0]   req_ready;
   logic              rsp_valid;
   logic [IDW-1:0]    rsp_id;
   logic [2*W-1:0]    rsp_prod;
   logic              rsp_ready = 1'b0;

   int n_cmp = 0, n_err = 0;

   // Model: who owns the multiplier and what it will hand back.
   int m_ptr = 0;
   int m_phase = 0;        // 0 free, 1 product being formed, 2 product on offer
   int m_op = 0, m_opid = 0;
   int m_prod = 0, m_id = 0;

   mult_arbiter #(.NREQ(NREQ), .W(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_prod(rsp_prod),
      .rsp_ready(rsp_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_ptr = 0; m_phase = 0; m_op = 0; m_opid = 0; m_prod = 0; m_id = 0;
   endtask

   // One clock: drive at negedge, check outputs, then advance the model by
   // the upcoming rising edge. g returns the granted requester or -1.
   task automatic step(input logic [NREQ-1:0] v, input logic [NREQ*W-1:0] a,
                       input logic [NREQ*W-1:0] b, input logic rr, output int g);
      int w;
      @(negedge clk);
      req_valid = v; req_a = a; req_b = b; rsp_ready = rr;
      #1;
      w = -1;
      if (m_phase == 0)
         for (int k = 0; k < NREQ; k++)
            if (w < 0 && v[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
      chk("req_ready", 32'(req_ready), (w >= 0) ? (32'd1 << w) : 32'd0);
      chk("rsp_valid", 32'(rsp_valid), 32'(m_phase == 2));
      chk("rsp_id",    32'(rsp_id),    32'(m_id));
      chk("rsp_prod",  32'(rsp_prod),  32'(m_prod));
      g = w;
      if (m_phase == 0) begin
         if (w >= 0) begin
            m_op   = int'(a[w*W +: W]) * int'(b[w*W +: W]);
            m_opid = w;
            m_ptr  = (w + 1) % NREQ;
            m_phase = 1;
         end
      end else if (m_phase == 1) begin
         m_prod = m_op; m_id = m_opid; m_phase = 2;
      end else if (rr) begin
         m_phase = 0;
      end
   endtask

   logic [NREQ*W-1:0] va, vb;
   logic [NREQ-1:0]   pend;
   logic [W-1:0]      pa [NREQ];
   logic [W-1:0]      pb [NREQ];
   int g;

   initial begin
      // Reset state, with requests already present.
      req_valid = '1;
      #2;
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_valid", 32'(rsp_valid), 32'd0);
      chk("rst_id",    32'(rsp_id),    32'd0);
      chk("rst_prod",  32'(rsp_prod),  32'd0);
      @(negedge clk); req_valid = '0; rst_n = 1'b1;
      model_reset();

      // Single request from requester 2: 15*15 must not truncate.
      va = '0; vb = '0; va[2*W +: W] = 4'hF; vb[2*W +: W] = 4'hF;
      step(4'b0100, va, vb, 1'b1, g);
      chk("single_grant", 32'(g), 32'd2);
      step(4'b0000, va, vb, 1'b1, g);
      chk("single_ready_pulse", 32'(req_ready), 32'd0);
      step(4'b0000, va, vb, 1'b1, g);
      chk("single_prod", 32'(rsp_prod), 32'hE1);
      chk("single_id",   32'(rsp_id),   32'd2);

      // Pointer now 3; only requester 1 valid -> wrap and skip to 1.
      va = '0; vb = '0; va[1*W +: W] = 4'h3; vb[1*W +: W] = 4'h5;
      step(4'b0010, va, vb, 1'b1, g);
      chk("wrap_grant", 32'(g), 32'd1);
      step(4'b0000, va, vb, 1'b1, g);
      step(4'b0000, va, vb, 1'b1, g);
      va[2*W +: W] = 4'h2; vb[2*W +: W] = 4'h2; va[3*W +: W] = 4'h1; vb[3*W +: W] = 4'h1;
      step(4'b1110, va, vb, 1'b1, g);
      chk("wrap_next_ptr2", 32'(g), 32'd2);
      step(4'b0000, va, vb, 1'b1, g);
      step(4'b0000, va, vb, 1'b1, g);

      // Zero operand.
      va = '0; vb = '0; vb[0 +: W] = 4'h9;
      step(4'b0001, va, vb, 1'b1, g);
      step(4'b0000, va, vb, 1'b1, g);
      step(4'b0000, va, vb, 1'b1, g);
      chk("zero_prod", 32'(rsp_prod), 32'd0);

      // Fairness from a fresh pointer: 0,1,2,3,0,... one grant every 3 cycles.
      @(negedge clk); req_valid = '0; rst_n = 1'b0; #1; model_reset();
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < NREQ; i++) begin va[i*W +: W] = W'(i + 1); vb[i*W +: W] = W'(i + 7); end
      for (int n = 0; n < 15; n++) begin
         step('1, va, vb, 1'b1, g);
         if (n % 3 == 0) chk("rr_order", 32'(g), 32'(n / 3 % NREQ));
         else            chk("rr_gap",   32'(g), 32'hFFFF_FFFF);
      end
      // Finish the in-flight op so the bench is aligned to a response.
      step('0, va, vb, 1'b1, g);
      step('0, va, vb, 1'b1, g);

      // Backpressure: requester 0 valid throughout, response held for 5 cycles.
      step(4'b0001, va, vb, 1'b0, g);
      step(4'b0001, va, vb, 1'b0, g);
      for (int n = 0; n < 5; n++) begin
         step(4'b0001, va, vb, 1'b0, g);
         chk("bp_ready", 32'(req_ready), 32'd0);
         chk("bp_prod",  32'(rsp_prod),  32'(1 * 7));
      end
      step(4'b0001, va, vb, 1'b1, g);
      chk("bp_release_ready", 32'(req_ready), 32'd0);
      step(4'b0001, va, vb, 1'b1, g);
      chk("bp_regrant", 32'(g), 32'd0);
      step('0, va, vb, 1'b1, g);
      step('0, va, vb, 1'b1, g);

      // Reset while a 6*7 product is on offer.
      va = '0; vb = '0; va[3*W +: W] = 4'h6; vb[3*W +: W] = 4'h7;
      step(4'b1000, va, vb, 1'b0, g);
      step(4'b0000, va, vb, 1'b0, g);
      @(posedge clk); #1;
      chk("pre_rst_prod", 32'(rsp_prod), 32'h2A);
      req_valid = '1;
      rst_n = 1'b0; #1;
      chk("async_rst_valid", 32'(rsp_valid), 32'd0);
      chk("async_rst_prod",  32'(rsp_prod),  32'd0);
      chk("async_rst_id",    32'(rsp_id),    32'd0);
      chk("async_rst_ready", 32'(req_ready), 32'd0);
      model_reset();
      @(negedge clk); req_valid = '0; rst_n = 1'b1;
      step('1, va, vb, 1'b1, g);
      chk("post_rst_grant", 32'(g), 32'd0);
      step('0, va, vb, 1'b1, g);
      step('0, va, vb, 1'b1, g);

      // Random traffic: requesters hold until granted, occasionally withdraw.
      pend = '0;
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!pend[i] && $urandom_range(2) == 0) begin
               pend[i] = 1'b1;
               pa[i] = W'($urandom); pb[i] = W'($urandom);
            end else if (pend[i] && $urandom_range(15) == 0) begin
               pend[i] = 1'b0;
            end
            va[i*W +: W] = pa[i]; vb[i*W +: W] = pb[i];
         end
         step(pend, va, vb, ($urandom_range(3) != 0), g);
         if (g >= 0) pend[g] = 1'b0;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
